// File: rtl/dcache_line_mover.sv
// Line-transfer engine for the dcache data SRAM: optional victim writeback
// (SRAM -> memory write stream) followed by a line fill (memory -> SRAM).
module dcache_line_mover #(
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned SRAM_AW    = 9
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      start,
  input  logic                                      writeback,
  input  logic [SRAM_AW-$clog2(LINE_WORDS)-1:0]     line_idx,
  input  logic [31:0]                               evict_addr,
  input  logic [31:0]                               fill_addr,
  output logic                                      busy,
  output logic                                      done,
  output logic [SRAM_AW-1:0]                        sram_addr,
  output logic                                      sram_we,
  output logic [31:0]                               sram_datain,
  input  logic [31:0]                               sram_dataout,
  output logic                                      mem_wr_valid,
  input  logic                                      mem_wr_ready,
  output logic [31:0]                               mem_wr_addr,
  output logic [31:0]                               mem_wr_data,
  output logic                                      mem_rd_valid,
  input  logic                                      mem_rd_ready,
  output logic [31:0]                               mem_rd_addr,
  input  logic                                      mem_rsp_valid,
  input  logic [31:0]                               mem_rsp_data
);

  localparam int unsigned CNT_W = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W = SRAM_AW - CNT_W;
  localparam int unsigned OFF_W = CNT_W + 2;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE, WB_RD, WB_SEND, FILL_REQ, FILL_WAIT, DONE
  } state_t;

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic [IDX_W-1:0]       idx_q;
  logic [31-OFF_W:0]      evict_q, fill_q;
  logic                   unused_addr_lsbs;

  // Byte offsets inside a line are dropped; bases are held line-aligned.
  assign unused_addr_lsbs = ^{evict_addr[OFF_W-1:0], fill_addr[OFF_W-1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      idx_q   <= '0;
      evict_q <= '0;
      fill_q  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && start) begin
        idx_q   <= line_idx;
        evict_q <= evict_addr[31:OFF_W];
        fill_q  <= fill_addr[31:OFF_W];
      end
    end
  end

  // Next state and port drive; valids and write enable are cut during reset.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    busy         = 1'b0;
    done         = 1'b0;
    sram_addr    = '0;
    sram_we      = 1'b0;
    sram_datain  = '0;
    mem_wr_valid = 1'b0;
    mem_wr_addr  = '0;
    mem_wr_data  = '0;
    mem_rd_valid = 1'b0;
    mem_rd_addr  = '0;
    case (state)
      IDLE: begin
        if (start) begin
          cnt_nxt   = '0;
          state_nxt = writeback ? WB_RD : FILL_REQ;
        end
      end
      WB_RD: begin
        busy      = 1'b1;
        sram_addr = {idx_q, cnt};
        state_nxt = WB_SEND;
      end
      WB_SEND: begin
        busy         = 1'b1;
        sram_addr    = {idx_q, cnt};
        mem_wr_valid = ~reset;
        mem_wr_addr  = {evict_q, cnt, 2'b00};
        mem_wr_data  = sram_dataout;
        if (mem_wr_ready) begin
          if (cnt == LAST_CNT) begin
            cnt_nxt   = '0;
            state_nxt = FILL_REQ;
          end else begin
            cnt_nxt   = cnt + CNT_W'(1);
            state_nxt = WB_RD;
          end
        end
      end
      FILL_REQ: begin
        busy         = 1'b1;
        mem_rd_valid = ~reset;
        mem_rd_addr  = {fill_q, cnt, 2'b00};
        if (mem_rd_ready) state_nxt = FILL_WAIT;
      end
      FILL_WAIT: begin
        busy = 1'b1;
        if (mem_rsp_valid) begin
          sram_we     = ~reset;
          sram_addr   = {idx_q, cnt};
          sram_datain = mem_rsp_data;
          if (cnt == LAST_CNT) begin
            state_nxt = DONE;
          end else begin
            cnt_nxt   = cnt + CNT_W'(1);
            state_nxt = FILL_REQ;
          end
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/dcache_line_mover.md
Name: dcache_line_mover

Overview:
- Line-transfer engine that drives the data-cache single-port 512x32 SRAM as its initiator.
- On a miss, the cache controller pulses start. The block then optionally writes the dirty victim line back to memory (SRAM read -> memory write stream) and fills the new line (memory read -> SRAM write).
- Sits between the dcache controller, the data SRAM and the memory-side bus port.
- Owns the SRAM port only while busy=1; the controller muxes the SRAM port on busy.

Parameters:
- LINE_WORDS, 8, 32-bit words per cache line; power of two, 2..64.
- SRAM_AW, 9, SRAM word-address width; line index width IDX_W = SRAM_AW - log2(LINE_WORDS) (6 at defaults).

Ports:
- clk  in  1  clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request pulse; sampled only in IDLE.
- writeback  in  1  1 = evict the victim line before filling; latched with start.
- line_idx  in  IDX_W  cache line index; latched with start.
- evict_addr  in  32  victim line byte address; latched; low log2(LINE_WORDS)+2 bits forced 0.
- fill_addr  in  32  new line byte address; latched; same alignment forcing.
- busy  out  1  high from the cycle after an accepted start through the DONE cycle.
- done  out  1  one-cycle pulse when the transfer completes.
- sram_addr  out  SRAM_AW  {line_idx_q, word_cnt}.
- sram_we  out  1  SRAM write enable.
- sram_datain  out  32  SRAM write data.
- sram_dataout  in  32  SRAM read data; valid 1 cycle after the address is presented with sram_we=0, and held while the address is held.
- mem_wr_valid  out  1  writeback word valid.
- mem_wr_ready  in  1  writeback word accepted when valid&ready.
- mem_wr_addr  out  32  evict_addr_q + 4*word_cnt.
- mem_wr_data  out  32  writeback data.
- mem_rd_valid  out  1  read request valid.
- mem_rd_ready  in  1  read request accepted when valid&ready.
- mem_rd_addr  out  32  fill_addr_q + 4*word_cnt.
- mem_rsp_valid  in  1  read response strobe; exactly one per accepted request, in order.
- mem_rsp_data  in  32  read response data.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values:
  - state=IDLE, word_cnt=0.
  - busy, done, sram_we, mem_wr_valid, mem_rd_valid all 0.
  - sram_addr, sram_datain, mem_wr_addr, mem_wr_data, mem_rd_addr all 0.
- Reset mid-operation: abort immediately, no further SRAM writes. A response arriving after reset is ignored.
- States: IDLE, WB_RD, WB_SEND, FILL_REQ, FILL_WAIT, DONE.
- IDLE:
  - start=1: latch inputs, word_cnt=0; go to WB_RD if writeback=1, else FILL_REQ.
  - start while busy is ignored.
- WB_RD:
  - sram_addr={idx,cnt}, sram_we=0.
  - Next cycle -> WB_SEND.
- WB_SEND:
  - sram_addr held; mem_wr_valid=1; mem_wr_data=sram_dataout (combinational pass-through); mem_wr_addr per cnt.
  - On mem_wr_ready: if cnt==LINE_WORDS-1 then cnt=0 -> FILL_REQ; else cnt+1 -> WB_RD.
  - Without ready: hold; valid, addr and data stay stable.
- FILL_REQ:
  - mem_rd_valid=1, mem_rd_addr per cnt.
  - On mem_rd_ready -> FILL_WAIT.
  - mem_rsp_valid is ignored in this state.
- FILL_WAIT:
  - mem_rd_valid=0.
  - On mem_rsp_valid, in the same cycle: sram_we=1, sram_addr={idx,cnt}, sram_datain=mem_rsp_data.
  - Then if cnt==LINE_WORDS-1 -> DONE; else cnt+1 -> FILL_REQ.
  - A response in the same cycle as request acceptance is not possible (in-order, at least 1 cycle later).
- DONE:
  - done=1 for exactly one cycle; busy=1; no SRAM or memory activity.
  - Next cycle -> IDLE, busy=0.
  - start in this cycle is ignored.
- Outside the states named above, sram_we=0 and mem_*_valid=0.
- Address arithmetic:
  - Offset 4*cnt is added to the line-aligned base. No carry leaves the line field.
  - 32-bit wrap at 0xFFFFFFE0+ is natural modulo 2^32.
- Latency at defaults with zero backpressure and 1-cycle response:
  - Writeback phase: 2 cycles/word = 16 cycles.
  - Fill phase: 2 cycles/word = 16 cycles.
  - DONE: 1 cycle.
  - start -> done: 33 cycles with writeback, 17 cycles without.
- SRAM is never written during the writeback phase and never read-dependent during fill.

Test Plan:
- Clean fill:
  - Stimulus: writeback=0, line_idx=5, fill_addr=0x1000; memory returns 0xA0+k one cycle after each request.
  - Required: 8 requests at 0x1000..0x101C; SRAM words 40..47 = 0xA0..0xA7; done 17 cycles after start; busy low the next cycle.
- Writeback then fill:
  - Stimulus: SRAM line 3 (addr 24..31) preloaded with 0x55000000+k; writeback=1, evict_addr=0x2000, fill_addr=0x3000; mem_wr_ready tied high.
  - Required: mem writes (0x2000+4k, 0x55000000+k) in order, then fill of line 3; done 33 cycles after start.
- Backpressure:
  - Stimulus: mem_wr_ready low for 5 cycles on word 2; mem_rd_ready low for 3 cycles on fill word 6.
  - Required: mem_wr_valid, mem_wr_addr and mem_wr_data stable while stalled; no duplicated or skipped words; SRAM contents correct.
- Misalignment and ignored inputs:
  - Stimulus: fill_addr=0x100F; start asserted again while busy; spurious mem_rsp_valid while in FILL_REQ.
  - Required: requests begin at 0x1000; second start ignored; spurious response not written to SRAM.
- Reset mid-fill:
  - Stimulus: assert reset after word 3 of a fill; a late response arrives after reset.
  - Required: all outputs at reset values next cycle; SRAM words 4..7 unchanged; late response ignored.
- Back-to-back:
  - Stimulus: start issued in the cycle after done.
  - Required: accepted; new transfer runs correctly.
